key_state: RTL and testbench

Upstream of the seven-segment status display: turns the four raw, bouncing, active-low Mario control buttons into the 6-bit `state_no` code the display consumes (IDLE/JUMP/SPEED/LEFT/RIGHT). Each button is synchronised and debounced, the buttons are priority-encoded, and every non-idle code is held for a minimum time so a tap stays readable on the LEDs. A one-cycle change strobe goes to the game logic.

---
 rtl/key_state_pkg.sv | 39 +++
 rtl/key_debounce.sv | 57 +++++
 rtl/key_state.sv | 121 ++++++++++++
 tb/tb_key_state.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_state_pkg.sv
// key_state_pkg
// Shared definitions for the Mario control-button path and the seven-segment
// status display: the 6-bit state-code width, the five state codes, the FSM
// state type used by key_state and the button priority encoder.
// The display stage imports these codes and does not redefine them.
package key_state_pkg;

   localparam int CODE_W = 6;

   localparam logic [CODE_W-1:0] IDLE  = 6'd0;
   localparam logic [CODE_W-1:0] JUMP  = 6'd1;
   localparam logic [CODE_W-1:0] SPEED = 6'd2;
   localparam logic [CODE_W-1:0] LEFT  = 6'd3;
   localparam logic [CODE_W-1:0] RIGHT = 6'd4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_HOLD = 2'd2
   } fsm_t;

   // Lowest set bit wins: jump > speed > left > right; nothing pressed -> IDLE.
   function automatic logic [CODE_W-1:0] prio_req(input logic [3:0] lvl);
      logic [CODE_W-1:0] code;
      if (lvl[0]) begin
         code = JUMP;
      end else if (lvl[1]) begin
         code = SPEED;
      end else if (lvl[2]) begin
         code = LEFT;
      end else if (lvl[3]) begin
         code = RIGHT;
      end else begin
         code = IDLE;
      end
      return code;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// One button: two-flop synchroniser followed by a debounce counter. The
// debounced level only flips after DEB_CNT consecutive cycles in which the
// synchronised value disagrees with it; any agreeing cycle restarts the count.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   key_n    raw button, low = pressed, asynchronous to clk
//   key_lvl  debounced level, 1 = pressed
module key_debounce #(
   parameter int DEB_CNT = 1_000_000,
   parameter int DEB_W   = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_lvl
);

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             pressed_s;
   logic [DEB_W-1:0] cnt_r;

   // Two-stage synchroniser; resets to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   // Debounce counter and registered debounced level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {DEB_W{1'b0}};
         key_lvl <= 1'b0;
      end else if (pressed_s == key_lvl) begin
         cnt_r   <= {DEB_W{1'b0}};
         key_lvl <= key_lvl;
      end else if (cnt_r == DEB_LAST) begin
         cnt_r   <= {DEB_W{1'b0}};
         key_lvl <= pressed_s;
      end else begin
         cnt_r   <= cnt_r + DEB_W'(1);
         key_lvl <= key_lvl;
      end
   end

endmodule

// File: rtl/key_state.sv
// key_state
// Turns the four raw Mario buttons into the 6-bit state code shown on the
// seven-segment display. Each button is debounced, the debounced levels are
// priority encoded, and any non-idle code is held on state_no for at least
// HOLD_CNT cycles so that a short tap stays readable.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_n[3:0] raw buttons, low = pressed (0 jump, 1 speed, 2 left, 3 right)
//   key_lvl    debounced levels, 1 = pressed, same bit order as key_n
//   state_no   displayed code: IDLE/JUMP/SPEED/LEFT/RIGHT
//   state_chg  one-cycle pulse in the cycle state_no takes a new value
module key_state
   import key_state_pkg::*;
#(
   parameter int DEB_CNT  = 1_000_000,
   parameter int HOLD_CNT = 25_000_000,
   parameter int DEB_W    = 20,
   parameter int HOLD_W   = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        key_n,
   output logic [3:0]        key_lvl,
   output logic [CODE_W-1:0] state_no,
   output logic              state_chg
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

   fsm_t              state_r;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_dec_s;
   logic [CODE_W-1:0] req_s;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_deb
         key_debounce #(
            .DEB_CNT (DEB_CNT),
            .DEB_W   (DEB_W)
         ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_n   (key_n[gi]),
            .key_lvl (key_lvl[gi])
         );
      end
   endgenerate

   assign req_s = prio_req(key_lvl);

   // Hold counter saturates at zero once the minimum display time has elapsed.
   assign hold_dec_s = (hold_cnt_r == HOLD_ZERO) ? HOLD_ZERO : (hold_cnt_r - HOLD_W'(1));

   // Display FSM with registered code, hold counter and change strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         hold_cnt_r <= HOLD_ZERO;
         state_no   <= IDLE;
         state_chg  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req_s != IDLE) begin
                  state_no   <= req_s;
                  hold_cnt_r <= HOLD_LAST;
                  state_chg  <= 1'b1;
                  state_r    <= S_SHOW;
               end else begin
                  state_chg  <= 1'b0;
               end
            end
            S_SHOW: begin
               if (req_s == state_no) begin
                  hold_cnt_r <= hold_dec_s;
                  state_chg  <= 1'b0;
               end else if (req_s != IDLE) begin
                  // A different key takes over at once, no hold wait.
                  state_no   <= req_s;
                  hold_cnt_r <= HOLD_LAST;
                  state_chg  <= 1'b1;
               end else if (hold_cnt_r == HOLD_ZERO) begin
                  state_no   <= IDLE;
                  state_chg  <= 1'b1;
                  state_r    <= S_IDLE;
               end else begin
                  hold_cnt_r <= hold_dec_s;
                  state_chg  <= 1'b0;
                  state_r    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (req_s != IDLE) begin
                  // A re-press of the same key restarts the hold silently.
                  state_chg  <= (req_s != state_no);
                  state_no   <= req_s;
                  hold_cnt_r <= HOLD_LAST;
                  state_r    <= S_SHOW;
               end else if (hold_cnt_r == HOLD_ZERO) begin
                  state_no   <= IDLE;
                  state_chg  <= 1'b1;
                  state_r    <= S_IDLE;
               end else begin
                  hold_cnt_r <= hold_dec_s;
                  state_chg  <= 1'b0;
               end
            end
            default: begin
               state_r    <= S_IDLE;
               hold_cnt_r <= HOLD_ZERO;
               state_no   <= IDLE;
               state_chg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_state.sv
// tb_key_state
// Self-checking bench for key_state with DEB_CNT=4, HOLD_CNT=8. A behavioural
// model (debounce as a run length of disagreeing samples, display hold as
// elapsed cycles since the code was last set) is compared with the DUT on
// every falling clock edge; directed sequences and a vector table add
// hand-computed expectations.
module tb_key_state;
   import key_state_pkg::*;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key_n = 4'hF;
   logic [3:0] key_lvl;
   logic [5:0] state_no;
   logic       state_chg;

   int checks = 0;
   int failures = 0;

   key_state #(
      .DEB_CNT  (DEB),
      .HOLD_CNT (HOLD),
      .DEB_W    (3),
      .HOLD_W   (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n     (key_n),
      .key_lvl   (key_lvl),
      .state_no  (state_no),
      .state_chg (state_chg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit [3:0] m_s1 = 4'hF;
   bit [3:0] m_s2 = 4'hF;
   bit [3:0] m_lvl = 4'h0;
   int       m_run [4] = '{0, 0, 0, 0};
   int       m_code = 0;
   int       m_set = 0;
   int       m_now = 0;
   bit       m_pend = 1'b0;
   bit       m_chg = 1'b0;

   function automatic int m_req(input bit [3:0] l);
      for (int i = 0; i < 4; i++) if (l[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'h0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_code = 0; m_set = 0; m_now = 0; m_pend = 1'b0; m_chg = 1'b0;
   endtask

   task automatic model_step();
      int req;
      bit pressed;
      req = m_req(m_lvl);
      m_now++;
      m_chg = 1'b0;
      if (req != 0) begin
         if (req != m_code) begin
            m_code = req; m_set = m_now; m_chg = 1'b1; m_pend = 1'b0;
         end else if (m_pend) begin
            m_set = m_now; m_pend = 1'b0;
         end
      end else if (m_code != 0) begin
         if (m_now - m_set >= HOLD) begin
            m_code = 0; m_chg = 1'b1; m_pend = 1'b0;
         end else begin
            m_pend = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         pressed = ~m_s2[i];
         if (pressed != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_lvl[i] = pressed;
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      check("model_lvl", 32'(key_lvl), 32'(m_lvl));
      check("model_state", 32'(state_no), 32'(m_code));
      check("model_chg", 32'(state_chg), 32'(m_chg));
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [3:0] kn;
      int         cyc;
      int         exp_state;
      logic [3:0] exp_lvl;
   } vec_t;

   vec_t vecs [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{4'b1110, 20, 1, 4'b0001};
      vecs[1] = '{4'b1111, 20, 0, 4'b0000};
      vecs[2] = '{4'b1001, 20, 2, 4'b0110};
      vecs[3] = '{4'b1011, 20, 3, 4'b0100};
      vecs[4] = '{4'b0000, 20, 1, 4'b1111};
      vecs[5] = '{4'b0111, 20, 4, 4'b1000};
      vecs[6] = '{4'b1111, 30, 0, 4'b0000};
      vecs[7] = '{4'b0101, 20, 2, 4'b1010};
      vecs[8] = '{4'b1111, 30, 0, 4'b0000};

      rst_n = 1'b0;
      key_n = 4'hF;
      repeat (3) step();
      rst_n = 1'b1;

      // Reset state held for 50 cycles with all keys released.
      for (int i = 0; i < 50; i++) begin
         step();
         check("reset_state", 32'(state_no), 32'(0));
         check("reset_lvl", 32'(key_lvl), 32'(0));
         check("reset_chg", 32'(state_chg), 32'(0));
      end

      // Clean press of jump, then release.
      key_n = 4'b1110;
      for (int e = 1; e <= 20; e++) begin
         step();
         check("press_lvl0", 32'(key_lvl[0]), 32'(e >= 6));
         check("press_state", 32'(state_no), (e >= 7) ? 32'(1) : 32'(0));
         check("press_chg", 32'(state_chg), 32'(e == 7));
      end
      key_n = 4'b1111;
      for (int r = 1; r <= 15; r++) begin
         step();
         check("release_lvl0", 32'(key_lvl[0]), 32'(r < 6));
         check("release_state", 32'(state_no), (r < 7) ? 32'(1) : 32'(0));
         check("release_chg", 32'(state_chg), 32'(r == 7));
      end

      // Tap of right shorter than the hold time.
      key_n = 4'b0111;
      for (int e = 1; e <= 25; e++) begin
         step();
         check("tap_lvl3", 32'(key_lvl[3]), 32'(e >= 6 && e <= 11));
         check("tap_state", 32'(state_no), (e >= 7 && e <= 14) ? 32'(4) : 32'(0));
         check("tap_chg", 32'(state_chg), 32'(e == 7 || e == 15));
         if (e == 6) key_n = 4'b1111;
      end

      // Bouncing left key, then a steady press.
      for (int p = 0; p < 10; p++) begin
         key_n = (p % 2 == 0) ? 4'b1011 : 4'b1111;
         for (int k = 0; k < 2; k++) begin
            step();
            check("bounce_lvl", 32'(key_lvl), 32'(0));
         end
      end
      key_n = 4'b1011;
      for (int e = 1; e <= 10; e++) begin
         step();
         check("bounce_state", 32'(state_no), (e >= 7) ? 32'(3) : 32'(0));
         check("bounce_chg", 32'(state_chg), 32'(e == 7));
      end
      key_n = 4'b1111;
      repeat (20) step();

      // Speed and left together, then speed released.
      key_n = 4'b1001;
      repeat (20) step();
      check("prio_both", 32'(state_no), 32'(2));
      key_n = 4'b1011;
      for (int r = 1; r <= 10; r++) begin
         step();
         check("prio_switch", 32'(state_no), (r >= 7) ? 32'(3) : 32'(2));
         check("prio_chg", 32'(state_chg), 32'(r == 7));
      end
      key_n = 4'b1111;
      repeat (25) step();

      // Asynchronous reset while jump is on display.
      key_n = 4'b1110;
      repeat (10) step();
      check("midrst_pre", 32'(state_no), 32'(1));
      #2;
      rst_n = 1'b0;
      key_n = 4'b1111;
      #1;
      check("midrst_state", 32'(state_no), 32'(0));
      check("midrst_lvl", 32'(key_lvl), 32'(0));
      check("midrst_chg", 32'(state_chg), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         check("midrst_post_chg", 32'(state_chg), 32'(0));
         check("midrst_post_state", 32'(state_no), 32'(0));
      end

      // Vector table.
      for (int i = 0; i < 9; i++) begin
         key_n = vecs[i].kn;
         repeat (vecs[i].cyc) step();
         check("vec_state", 32'(state_no), 32'(vecs[i].exp_state));
         check("vec_lvl", 32'(key_lvl), 32'(vecs[i].exp_lvl));
      end

      // Random key activity checked against the model on every cycle.
      for (int it = 0; it < 250; it++) begin
         if ($urandom_range(0, 1) == 0) key_n = 4'hF;
         else key_n = 4'($urandom_range(0, 15));
         repeat ($urandom_range(1, 14)) step();
      end
      key_n = 4'hF;
      repeat (30) step();
      check("final_idle", 32'(state_no), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
